// File: rtl/threshold_fifo_pkg.sv
// Shared FIFO helpers: pointer/fill widths derived from depth, and the
// per-cycle operation encoding used by the fill-level update.
package threshold_fifo_pkg;

  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_PUSH = 2'b01,
    OP_POP  = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // One extra bit so a completely full FIFO is distinguishable from empty.
  function automatic int fill_w(input int depth);
    return ptr_w(depth) + 1;
  endfunction

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/threshold_fifo_dpram.sv
// Storage array for threshold_fifo: one synchronous write port, one
// asynchronous read port. Contents are never reset.
module fifo_dpram #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  parameter int AW    = 4
) (
  input  logic             i_clock,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic [AW-1:0]    i_rd_addr,
  output logic [WIDTH-1:0] o_rd_data
);

  logic [WIDTH-1:0] r_mem [0:DEPTH-1];

  always_ff @(posedge i_clock) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/threshold_fifo.sv
// Single-clock FIFO with programmable almost-full/almost-empty thresholds,
// sticky overflow/underflow flags and optional first-word-fall-through output.
module threshold_fifo
  import threshold_fifo_pkg::*;
#(
  parameter int nrOfEntries      = 16,
  parameter int bitWidth         = 8,
  parameter int almostFullLevel  = nrOfEntries - 2,
  parameter int almostEmptyLevel = 2,
  parameter int fwftMode         = 0
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             push,
  input  logic                             pop,
  input  logic [bitWidth-1:0]              pushData,
  input  logic                             clearErrors,
  output logic [bitWidth-1:0]              popData,
  output logic                             full,
  output logic                             empty,
  output logic                             almostFull,
  output logic                             almostEmpty,
  output logic [fill_w(nrOfEntries)-1:0]   fillLevel,
  output logic                             overflow,
  output logic                             underflow
);

  localparam int PW = ptr_w(nrOfEntries);
  localparam int FW = fill_w(nrOfEntries);

  if (!is_pow2(nrOfEntries) || nrOfEntries < 4 || nrOfEntries > 1024) begin : g_bad_depth
    $error("threshold_fifo: nrOfEntries must be a power of two in 4..1024");
  end
  if (bitWidth < 1 || bitWidth > 64) begin : g_bad_width
    $error("threshold_fifo: bitWidth must be in 1..64");
  end
  if (!(almostEmptyLevel < almostFullLevel && almostFullLevel <= nrOfEntries)) begin : g_bad_levels
    $error("threshold_fifo: need almostEmptyLevel < almostFullLevel <= nrOfEntries");
  end

  logic [PW-1:0]       r_wr_ptr;
  logic [PW-1:0]       r_rd_ptr;
  logic [FW-1:0]       r_fill;
  logic                r_overflow;
  logic                r_underflow;
  logic                w_pop_acc;
  logic                w_push_acc;
  logic                w_ovf_set;
  logic                w_unf_set;
  logic [bitWidth-1:0] w_rd_data;
  fifo_op_e            w_op;

  assign full        = (r_fill == FW'(nrOfEntries));
  assign empty       = (r_fill == '0);
  assign almostFull  = (r_fill >= FW'(almostFullLevel));
  assign almostEmpty = (r_fill <= FW'(almostEmptyLevel));
  assign fillLevel   = r_fill;
  assign overflow    = r_overflow;
  assign underflow   = r_underflow;

  // A pop frees a slot in the same cycle, so a full FIFO still takes a push alongside it.
  assign w_pop_acc  = pop & ~empty;
  assign w_push_acc = push & (~full | w_pop_acc);
  assign w_ovf_set  = push & full & ~w_pop_acc;
  assign w_unf_set  = pop & empty;

  always_comb begin
    w_op = OP_IDLE;
    case ({w_pop_acc, w_push_acc})
      2'b01:   w_op = OP_PUSH;
      2'b10:   w_op = OP_POP;
      2'b11:   w_op = OP_BOTH;
      default: w_op = OP_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_fill      <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_push_acc) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop_acc)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case (w_op)
        OP_PUSH: r_fill <= r_fill + FW'(1);
        OP_POP:  r_fill <= r_fill - FW'(1);
        default: r_fill <= r_fill;
      endcase
      // A fresh error beats a simultaneous clear.
      r_overflow  <= w_ovf_set | (r_overflow  & ~clearErrors);
      r_underflow <= w_unf_set | (r_underflow & ~clearErrors);
    end
  end

  fifo_dpram #(
    .DEPTH (nrOfEntries),
    .WIDTH (bitWidth),
    .AW    (PW)
  ) u_mem (
    .i_clock   (clock),
    .i_wr_en   (w_push_acc),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (pushData),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (w_rd_data)
  );

  if (fwftMode != 0) begin : g_fwft
    assign popData = empty ? '0 : w_rd_data;
  end else begin : g_reg
    logic [bitWidth-1:0] r_pop_data;
    always_ff @(posedge clock) begin
      if (reset)          r_pop_data <= '0;
      else if (w_pop_acc) r_pop_data <= w_rd_data;
    end
    assign popData = r_pop_data;
  end

endmodule

// File: tb/tb_threshold_fifo.sv
// Drives a registered-read and an FWFT instance (depth 8, width 8) with the same
// stimulus and compares both against a queue-based reference model every cycle.
module tb_threshold_fifo;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       push = 1'b0;
  logic       pop = 1'b0;
  logic       clearErrors = 1'b0;
  logic [7:0] pushData = 8'h00;

  logic [7:0] popData_a, popData_b;
  logic       full_a, empty_a, af_a, ae_a, ovf_a, unf_a;
  logic       full_b, empty_b, af_b, ae_b, ovf_b, unf_b;
  logic [3:0] fill_a, fill_b;

  int checks = 0;
  int errors = 0;

  byte unsigned mq[$];
  logic [7:0]   m_pd = 8'h00;
  bit           m_ovf = 1'b0;
  bit           m_unf = 1'b0;

  always #5 clock = ~clock;

  threshold_fifo #(.nrOfEntries(8), .bitWidth(8), .fwftMode(0)) dut_a (
    .clock(clock), .reset(reset), .push(push), .pop(pop), .pushData(pushData),
    .clearErrors(clearErrors), .popData(popData_a), .full(full_a), .empty(empty_a),
    .almostFull(af_a), .almostEmpty(ae_a), .fillLevel(fill_a),
    .overflow(ovf_a), .underflow(unf_a)
  );

  threshold_fifo #(.nrOfEntries(8), .bitWidth(8), .fwftMode(1)) dut_b (
    .clock(clock), .reset(reset), .push(push), .pop(pop), .pushData(pushData),
    .clearErrors(clearErrors), .popData(popData_b), .full(full_b), .empty(empty_b),
    .almostFull(af_b), .almostEmpty(ae_b), .fillLevel(fill_b),
    .overflow(ovf_b), .underflow(unf_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    int n;
    n = mq.size();
    chk("fill_a", 32'(fill_a), n);
    chk("full_a", 32'(full_a), 32'(n == 8));
    chk("empty_a", 32'(empty_a), 32'(n == 0));
    chk("afull_a", 32'(af_a), 32'(n >= 6));
    chk("aempty_a", 32'(ae_a), 32'(n <= 2));
    chk("ovf_a", 32'(ovf_a), 32'(m_ovf));
    chk("unf_a", 32'(unf_a), 32'(m_unf));
    chk("data_a", 32'(popData_a), 32'(m_pd));
    chk("fill_b", 32'(fill_b), n);
    chk("empty_b", 32'(empty_b), 32'(n == 0));
    chk("full_b", 32'(full_b), 32'(n == 8));
    chk("ovf_b", 32'(ovf_b), 32'(m_ovf));
    chk("unf_b", 32'(unf_b), 32'(m_unf));
    if (n > 0) chk("data_b", 32'(popData_b), 32'(mq[0]));
  endtask

  // One clock: apply inputs, advance the model by the FIFO rules, compare.
  task automatic cyc(input bit r, input bit p, input bit q, input logic [7:0] d, input bit c);
    bit mfull, mempty, pok, uok;
    reset = r; push = p; pop = q; pushData = d; clearErrors = c;
    @(posedge clock);
    #1;
    if (r) begin
      mq.delete();
      m_pd = 8'h00; m_ovf = 1'b0; m_unf = 1'b0;
    end else begin
      mfull  = (mq.size() == 8);
      mempty = (mq.size() == 0);
      pok = q && !mempty;
      uok = p && (!mfull || pok);
      if (pok) m_pd = mq.pop_front();
      if (uok) mq.push_back(d);
      m_ovf = (p && mfull && !pok) || (m_ovf && !c);
      m_unf = (q && mempty) || (m_unf && !c);
    end
    reset = 1'b0; push = 1'b0; pop = 1'b0; clearErrors = 1'b0;
    compare_all();
  endtask

  initial begin
    cyc(1, 0, 0, 8'h00, 0);
    cyc(1, 1, 1, 8'h55, 1);
    chk("rst_empty", 32'(empty_a), 1);
    chk("rst_data", 32'(popData_a), 0);

    for (int i = 5; i <= 12; i++) begin
      cyc(0, 1, 0, 8'(i), 0);
      if (i == 10) chk("afull_at6", 32'(af_a), 1);
      if (i == 9)  chk("afull_at5", 32'(af_a), 0);
    end
    chk("fill_full", 32'(full_a), 1);
    chk("fill_lvl8", 32'(fill_a), 8);
    cyc(0, 1, 0, 8'd13, 0);
    chk("ovf_9th", 32'(ovf_a), 1);
    cyc(0, 0, 0, 8'h00, 1);

    for (int i = 0; i < 8; i++) begin
      cyc(0, 0, 1, 8'h00, 0);
      chk("drain_data", 32'(popData_a), 32'(5 + i));
    end
    chk("drain_empty", 32'(empty_a), 1);
    cyc(0, 0, 1, 8'h00, 0);
    chk("unf_9th", 32'(unf_a), 1);
    cyc(0, 0, 0, 8'h00, 1);

    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 8'($urandom), 0);
    for (int i = 0; i < 30; i++) cyc(0, 1, 1, 8'($urandom), 0);
    chk("steady_fill", 32'(fill_a), 4);
    chk("steady_errs", {30'd0, ovf_a, unf_a}, 0);

    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 8'h00, 0);
    cyc(0, 1, 0, 8'hA5, 0);
    chk("fwft_next", 32'(popData_b), 32'h A5);
    cyc(0, 0, 0, 8'h00, 0);
    chk("fwft_hold", 32'(popData_b), 32'hA5);
    cyc(0, 0, 1, 8'h00, 0);
    chk("fwft_empty", 32'(empty_b), 1);

    for (int i = 0; i < 8; i++) cyc(0, 1, 0, 8'($urandom), 0);
    cyc(0, 1, 0, 8'h77, 0);
    cyc(0, 1, 1, 8'($urandom), 0);
    chk("both_full", 32'(fill_a), 8);
    for (int i = 0; i < 8; i++) cyc(0, 0, 1, 8'h00, 0);
    cyc(0, 1, 1, 8'h3C, 0);
    chk("both_empty_fill", 32'(fill_a), 1);
    chk("both_empty_unf", 32'(unf_a), 1);
    cyc(0, 0, 0, 8'h00, 1);
    chk("clr_flags", {30'd0, ovf_a, unf_a}, 0);
    cyc(0, 0, 1, 8'h00, 0);
    cyc(0, 0, 1, 8'h00, 1);
    chk("clr_vs_err", 32'(unf_a), 1);
    cyc(0, 0, 0, 8'h00, 1);

    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 8'($urandom), 0);
    cyc(1, 0, 0, 8'h00, 0);
    chk("mid_rst_empty", 32'(empty_a), 1);
    chk("mid_rst_fill", 32'(fill_a), 0);
    cyc(0, 1, 0, 8'h11, 0);
    cyc(0, 0, 1, 8'h00, 0);
    chk("mid_rst_data", 32'(popData_a), 32'h11);

    for (int i = 0; i < 300; i++) begin
      cyc(($urandom_range(0, 59) == 0), ($urandom_range(0, 1) == 1),
          ($urandom_range(0, 1) == 1), 8'($urandom), ($urandom_range(0, 9) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/threshold_fifo.md
THRESHOLD_FIFO -- requirements
Module: threshold_fifo

Interface
REQ-001 SHALL have parameter nrOfEntries, default 16, depth in words; power of two, 4..1024.
REQ-002 SHALL have parameter bitWidth, default 8, data width in bits, 1..64.
REQ-003 SHALL have parameter almostFullLevel, default nrOfEntries-2, fill level at or above which almostFull asserts.
REQ-004 SHALL have parameter almostEmptyLevel, default 2, fill level at or below which almostEmpty asserts.
REQ-005 SHALL have parameter fwftMode, default 0; 0 = registered read, 1 = first-word-fall-through.
REQ-006 SHALL have port clock  input  1  single clock; all state updates on rising edge.
REQ-007 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-008 SHALL have port push  input  1  write request.
REQ-009 SHALL have port pop  input  1  read request.
REQ-010 SHALL have port pushData  input  bitWidth  write data.
REQ-011 SHALL have port clearErrors  input  1  clears sticky error flags.
REQ-012 SHALL have port popData  output  bitWidth  read data.
REQ-013 SHALL have port full, empty, almostFull, almostEmpty  output  1 each  status flags.
REQ-014 SHALL have port fillLevel  output  clog2(nrOfEntries)+1  current word count.
REQ-015 SHALL have port overflow, underflow  output  1 each  sticky error flags.

Function
REQ-016 SHALL accept a push when push=1 and (full=0 or an accepted pop occurs in the same cycle); the word is stored at the write pointer.
REQ-017 SHALL accept a pop when pop=1 and empty=0.
REQ-018 SHALL update fillLevel on the next edge: +1 for push only, -1 for pop only, unchanged for push+pop or none.
REQ-019 SHALL derive all flags from registered fillLevel: full = (fillLevel==nrOfEntries), empty = (fillLevel==0), almostFull = (fillLevel>=almostFullLevel), almostEmpty = (fillLevel<=almostEmptyLevel).
REQ-020 SHALL wrap read and write pointers modulo nrOfEntries with no gap or lost word.
REQ-021 SHALL, on push+pop while full, accept both; fillLevel stays nrOfEntries.
REQ-022 SHALL, on push+pop while empty, accept the push, ignore the pop, and set underflow.
REQ-023 SHALL set overflow on the edge after push=1 with full=1 and no accepted pop; the data is discarded and state is unchanged.
REQ-024 SHALL set underflow on the edge after pop=1 with empty=1; pointers are unchanged.
REQ-025 SHALL hold overflow and underflow until clearErrors=1 or reset; a new error in the same cycle as clearErrors wins (flag stays 1).
REQ-026 SHALL, when fwftMode=0, present the popped word on popData one cycle after the accepted pop and hold it until the next accepted pop.
REQ-027 SHALL, when fwftMode=1, present the head word on popData combinationally whenever empty=0, so pop acknowledges data already visible; popData is don't-care while empty.
REQ-028 SHALL write same-cycle push data to an empty FIFO so that it is visible on popData in the cycle after the push when fwftMode=1.

Reset
REQ-029 SHALL, on reset=1 at a rising edge, clear pointers and fillLevel and set empty=1, almostEmpty=1, full=0, almostFull=0 (unless almostFullLevel==0), overflow=0, underflow=0, popData=0.
REQ-030 SHALL give reset priority over push, pop and clearErrors in the same cycle; stored memory content need not be cleared.
REQ-031 SHALL allow reset mid-operation; the first accepted pop after reset returns the first word pushed after reset.

Structure
REQ-032 SHALL take its pointer-width and fill-width helper constants (clog2-derived) from the shared FIFO package/header.
REQ-033 SHALL instantiate one storage sub-module fifo_dpram (one write port, one asynchronous read port, bitWidth x nrOfEntries); all control stays in threshold_fifo.
REQ-034 SHALL be checked at elaboration: nrOfEntries power of two, and almostEmptyLevel < almostFullLevel <= nrOfEntries.

Verification
REQ-035 SHALL verify fill: depth 8, width 8, fwftMode=0; push 5..12 on 8 cycles -> full=1 at fillLevel=8, almostFull=1 from fillLevel=6, and a 9th push of 13 sets overflow.
REQ-036 SHALL verify drain: pop 8 times from the fill state -> popData 5..12 in order, each one cycle after its pop; then empty=1, and a 9th pop sets underflow.
REQ-037 SHALL verify steady state: with 4 words held, push+pop for 30 cycles -> fillLevel stays 4, data order is preserved across pointer wrap, and no error flags are set.
REQ-038 SHALL verify FWFT: with fwftMode=1, push 0xA5 into an empty FIFO -> popData=0xA5 on the next cycle with no pop; pop -> empty=1 on the next cycle.
REQ-039 SHALL verify boundary conditions: push+pop while full keeps fillLevel=8; push+pop while empty gives fillLevel=1 and underflow=1; clearErrors clears both flags next cycle.
REQ-040 SHALL verify reset mid-stream: reset after 3 pushes -> empty=1 and fillLevel=0 next cycle; after pushing 0x11 and popping, popData=0x11.
